// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared types and constants for the PS/2 keyboard sequencer:
//                sequencer states, prefix bytes, modifier key codes and the
//                key event record stored in the event FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } kbd_state_t;

    // Prefix bytes
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    // Scan codes with special meaning to the sequencer
    localparam logic [7:0] LSHIFT     = 8'h12;
    localparam logic [7:0] RSHIFT     = 8'h59;
    localparam logic [7:0] CTRL       = 8'h14;
    localparam logic [7:0] ALT        = 8'h11;
    localparam logic [7:0] PAUSE_CODE = 8'h77;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } key_event_t;

    // Bytes the keyboard sends as command responses rather than key codes
    function automatic logic is_device_response(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
               (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_fifo
//  Description : First-word-fall-through FIFO of key events. The head entry
//                is visible while empty_out is low. A push into a full FIFO
//                is accepted only when a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       push_in,
    input  key_event_t push_data_in,
    input  logic       pop_in,
    output key_event_t head_out,
    output logic       full_out,
    output logic       empty_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    key_event_t      mem_q [DEPTH];
    key_event_t      mem_d [DEPTH];
    logic [AW-1:0]   wr_q, wr_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push;
    logic            do_pop;

    assign full_out  = (count_q == CW'(DEPTH));
    assign empty_out = (count_q == '0);
    assign head_out  = mem_q[rd_q];

    // Pointer, occupancy and storage updates for one push and/or pop
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        do_pop  = pop_in && !empty_out;
        do_push = push_in && (!full_out || do_pop);
        if (do_push) begin
            mem_d[wr_q] = push_data_in;
            wr_d        = wr_q + AW'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_keyboard_ctrl
//  Description : Folds PS/2 scan-code byte sequences (E0/F0/E1 prefixes) into
//                single key events, tracks modifier levels and queues events
//                for a valid/ready consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_keyboard_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int PAUSE_SKIP     = 7
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] code_in,
    input  logic       code_valid_in,
    output logic [7:0] key_code_out,
    output logic       key_ext_out,
    output logic       key_release_out,
    output logic       key_valid_out,
    input  logic       key_ready_in,
    output logic       shift_out,
    output logic       ctrl_out,
    output logic       alt_out,
    output logic       overflow_out,
    output logic       timeout_out
);

    localparam int                  TMO_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0]    TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam int                  SKIP_W    = $clog2(PAUSE_SKIP + 1);
    localparam logic [SKIP_W-1:0]   SKIP_LAST = SKIP_W'(PAUSE_SKIP - 1);

    kbd_state_t        state_q, state_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic              lshift_q, lshift_d;
    logic              rshift_q, rshift_d;
    logic              ctrl_q, ctrl_d;
    logic              alt_q, alt_d;
    logic              overflow_q, overflow_d;
    logic              timeout_q, timeout_d;

    logic              push;
    logic              commit_mod;
    key_event_t        push_ev;
    key_event_t        head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;

    assign key_valid_out   = !fifo_empty;
    assign pop             = key_valid_out && key_ready_in;
    assign key_code_out    = head.code;
    assign key_ext_out     = head.ext;
    assign key_release_out = head.rel;
    assign shift_out       = lshift_q || rshift_q;
    assign ctrl_out        = ctrl_q;
    assign alt_out         = alt_q;
    assign overflow_out    = overflow_q;
    assign timeout_out     = timeout_q;

    // Sequencer: next state, pause skip count, idle timeout and event push
    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        skip_d     = skip_q;
        push       = 1'b0;
        commit_mod = 1'b0;
        push_ev    = '0;
        timeout_d  = 1'b0;
        if (code_valid_in) begin
            tmo_d = '0;
            if (state_q == ST_PAUSE) begin
                // Everything inside a pause sequence is absorbed, prefixes too
                skip_d = skip_q + SKIP_W'(1);
                if (skip_q == SKIP_LAST) begin
                    push         = 1'b1;
                    push_ev.ext  = 1'b1;
                    push_ev.code = PAUSE_CODE;
                    skip_d       = '0;
                    state_d      = ST_IDLE;
                end
            end else if (code_in == PS2_EXT) begin
                state_d = ST_EXT;
            end else if (code_in == PS2_PAUSE) begin
                state_d = ST_PAUSE;
                skip_d  = '0;
            end else if (code_in == PS2_BRK) begin
                unique case (state_q)
                    ST_IDLE: state_d = ST_BRK;
                    ST_EXT:  state_d = ST_EXT_BRK;
                    default: state_d = state_q;
                endcase
            end else if (state_q == ST_IDLE) begin
                if (!is_device_response(code_in)) begin
                    push         = 1'b1;
                    commit_mod   = 1'b1;
                    push_ev.code = code_in;
                end
            end else begin
                push         = 1'b1;
                commit_mod   = 1'b1;
                push_ev.ext  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
                push_ev.rel  = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
                push_ev.code = code_in;
                state_d      = ST_IDLE;
            end
        end else if (state_q == ST_IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            // A stalled partial sequence is abandoned
            state_d   = ST_IDLE;
            tmo_d     = '0;
            skip_d    = '0;
            timeout_d = 1'b1;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    // Modifier levels follow committed events, whether or not the FIFO keeps them
    always_comb begin
        lshift_d   = lshift_q;
        rshift_d   = rshift_q;
        ctrl_d     = ctrl_q;
        alt_d      = alt_q;
        overflow_d = push && fifo_full && !pop;
        if (commit_mod) begin
            // Extended 12/59 are fake shifts generated around navigation keys
            if (!push_ev.ext && (push_ev.code == LSHIFT)) lshift_d = !push_ev.rel;
            if (!push_ev.ext && (push_ev.code == RSHIFT)) rshift_d = !push_ev.rel;
            if (push_ev.code == CTRL) ctrl_d = !push_ev.rel;
            if (push_ev.code == ALT)  alt_d  = !push_ev.rel;
        end
    end

    // Sequencer, modifier and status-pulse registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= ST_IDLE;
            tmo_q      <= '0;
            skip_q     <= '0;
            lshift_q   <= 1'b0;
            rshift_q   <= 1'b0;
            ctrl_q     <= 1'b0;
            alt_q      <= 1'b0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            skip_q     <= skip_d;
            lshift_q   <= lshift_d;
            rshift_q   <= rshift_d;
            ctrl_q     <= ctrl_d;
            alt_q      <= alt_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
        end
    end

    key_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .push_in      (push),
        .push_data_in (push_ev),
        .pop_in       (pop),
        .head_out     (head),
        .full_out     (fifo_full),
        .empty_out    (fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_keyboard_ctrl
//  Description : Self-checking bench for ps2_keyboard_ctrl with a
//                prefix-flag reference model and event queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_keyboard_ctrl;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;
    localparam int SKIP  = 7;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic [7:0] code_in = '0;
    logic       code_valid_in = 1'b0;
    logic       key_ready_in = 1'b0;
    logic [7:0] key_code_out;
    logic       key_ext_out, key_release_out, key_valid_out;
    logic       shift_out, ctrl_out, alt_out, overflow_out, timeout_out;

    ps2_keyboard_ctrl #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .PAUSE_SKIP     (SKIP)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .code_in         (code_in),
        .code_valid_in   (code_valid_in),
        .key_code_out    (key_code_out),
        .key_ext_out     (key_ext_out),
        .key_release_out (key_release_out),
        .key_valid_out   (key_valid_out),
        .key_ready_in    (key_ready_in),
        .shift_out       (shift_out),
        .ctrl_out        (ctrl_out),
        .alt_out         (alt_out),
        .overflow_out    (overflow_out),
        .timeout_out     (timeout_out)
    );

    always #5 clk_in = ~clk_in;

    int tests = 0;
    int fails = 0;

    // Reference model: pending prefix flags plus an ordered queue of events
    logic [9:0] m_q[$];
    bit m_ext, m_brk, m_pause;
    int m_skip, m_idle;
    bit m_ls, m_rs, m_ctrl, m_alt, m_ovf, m_tmo;

    function automatic logic [9:0] head_now();
        return {key_ext_out, key_release_out, key_code_out};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ext = 0; m_brk = 0; m_pause = 0; m_skip = 0; m_idle = 0;
        m_ls = 0; m_rs = 0; m_ctrl = 0; m_alt = 0; m_ovf = 0; m_tmo = 0;
    endtask

    task automatic model_push(input logic [9:0] ev, input bit mods);
        if (m_q.size() < DEPTH) m_q.push_back(ev);
        else m_ovf = 1;
        if (mods) begin
            if (!ev[9] && ev[7:0] == 8'h12) m_ls = !ev[8];
            if (!ev[9] && ev[7:0] == 8'h59) m_rs = !ev[8];
            if (ev[7:0] == 8'h14) m_ctrl = !ev[8];
            if (ev[7:0] == 8'h11) m_alt  = !ev[8];
        end
    endtask

    // One clock: drive inputs, advance model, return 1 time unit after the edge
    task automatic step(input bit v, input logic [7:0] b, input bit r);
        m_ovf = 0;
        m_tmo = 0;
        if (r && m_q.size() > 0) void'(m_q.pop_front());
        if (v) begin
            m_idle = 0;
            if (m_pause) begin
                m_skip++;
                if (m_skip == SKIP) begin
                    model_push({2'b10, 8'h77}, 0);
                    m_pause = 0;
                end
            end else if (b == 8'hE0) begin
                m_ext = 1; m_brk = 0;
            end else if (b == 8'hE1) begin
                m_pause = 1; m_skip = 0; m_ext = 0; m_brk = 0;
            end else if (b == 8'hF0) begin
                m_brk = 1;
            end else if (!m_ext && !m_brk &&
                         (b == 8'h00 || b == 8'hAA || b == 8'hEE ||
                          b == 8'hFA || b == 8'hFE || b == 8'hFF)) begin
                // device response: no event
            end else begin
                model_push({m_ext, m_brk, b}, 1);
                m_ext = 0; m_brk = 0;
            end
        end else if (m_ext || m_brk || m_pause) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_ext = 0; m_brk = 0; m_pause = 0; m_idle = 0; m_tmo = 1;
            end
        end
        code_valid_in = v;
        code_in       = b;
        key_ready_in  = r;
        @(posedge clk_in);
        #1;
        code_valid_in = 1'b0;
        key_ready_in  = 1'b0;
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        model_reset();
        #2;
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({key_valid_out, head_now()} !== 11'h0) begin
            fails++;
            $display("FAIL reset_fifo got=%h exp=0", {key_valid_out, head_now()});
        end
        tests++;
        if ({shift_out, ctrl_out, alt_out, overflow_out, timeout_out} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {shift_out, ctrl_out, alt_out, overflow_out, timeout_out});
        end
    endtask

    task automatic test_make_break();
        step(1, 8'h1C, 0);
        tests++;
        if (key_valid_out !== 1'b1 || head_now() !== 10'h01C) begin
            fails++;
            $display("FAIL make_1c got=%b/%h exp=1/01c", key_valid_out, head_now());
        end
        step(0, 8'h00, 1);
        step(1, 8'hF0, 0);
        step(1, 8'h1C, 0);
        tests++;
        if (key_valid_out !== 1'b1 || head_now() !== 10'h11C) begin
            fails++;
            $display("FAIL break_1c got=%b/%h exp=1/11c", key_valid_out, head_now());
        end
        step(0, 8'h00, 1);
    endtask

    task automatic test_ext_break();
        step(1, 8'hE0, 1);
        step(1, 8'hF0, 1);
        step(1, 8'h75, 1);
        tests++;
        if (key_valid_out !== 1'b1 || head_now() !== 10'h375) begin
            fails++;
            $display("FAIL ext_break got=%b/%h exp=1/375", key_valid_out, head_now());
        end
        step(0, 8'h00, 1);
        tests++;
        if (key_valid_out !== 1'b0) begin
            fails++;
            $display("FAIL ext_break_pop got=%b exp=0", key_valid_out);
        end
    endtask

    task automatic test_modifiers();
        step(1, 8'h12, 1);
        tests++;
        if (shift_out !== 1'b1) begin
            fails++; $display("FAIL shift_make got=%b exp=1", shift_out);
        end
        step(1, 8'hF0, 1);
        step(1, 8'h12, 1);
        tests++;
        if (shift_out !== 1'b0) begin
            fails++; $display("FAIL shift_break got=%b exp=0", shift_out);
        end
        step(1, 8'hE0, 1);
        step(1, 8'h12, 1);
        tests++;
        if (shift_out !== 1'b0 || head_now() !== 10'h212) begin
            fails++;
            $display("FAIL fake_shift got=%b/%h exp=0/212", shift_out, head_now());
        end
        step(1, 8'hE0, 1);
        step(1, 8'h14, 1);
        step(1, 8'h11, 1);
        tests++;
        if ({ctrl_out, alt_out} !== 2'b11) begin
            fails++; $display("FAIL ctrl_alt got=%b exp=11", {ctrl_out, alt_out});
        end
        step(1, 8'hF0, 1);
        step(1, 8'h14, 1);
        step(1, 8'hF0, 1);
        step(1, 8'h11, 1);
        step(0, 8'h00, 1);
        tests++;
        if ({ctrl_out, alt_out, key_valid_out} !== 3'b000) begin
            fails++;
            $display("FAIL ctrl_alt_rel got=%b exp=000", {ctrl_out, alt_out, key_valid_out});
        end
    endtask

    task automatic test_pause();
        logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        foreach (seq[i]) step(1, seq[i], 0);
        tests++;
        if (key_valid_out !== 1'b1 || head_now() !== 10'h277 || ctrl_out !== 1'b0) begin
            fails++;
            $display("FAIL pause_event got=%b/%h ctrl=%b exp=1/277 ctrl=0",
                     key_valid_out, head_now(), ctrl_out);
        end
        step(0, 8'h00, 1);
        tests++;
        if (key_valid_out !== 1'b0) begin
            fails++; $display("FAIL pause_single got=%b exp=0", key_valid_out);
        end
    endtask

    task automatic test_overflow();
        int pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 8'h1C + 8'(i), 0);
            if (overflow_out === 1'b1) pulses++;
            step(0, 8'h00, 0);
            if (overflow_out === 1'b1) pulses++;
        end
        tests++;
        if (pulses != 1) begin
            fails++; $display("FAIL overflow_pulses got=%0d exp=1", pulses);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (key_valid_out !== 1'b1 || head_now() !== {2'b00, 8'h1C + 8'(i)}) begin
                fails++;
                $display("FAIL overflow_order%0d got=%b/%h exp=1/%h",
                         i, key_valid_out, head_now(), {2'b00, 8'h1C + 8'(i)});
            end
            step(0, 8'h00, 1);
        end
        tests++;
        if (key_valid_out !== 1'b0) begin
            fails++; $display("FAIL overflow_drain got=%b exp=0", key_valid_out);
        end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] exp [4] = '{8'h1D, 8'h1E, 8'h1F, 8'h2A};
        for (int i = 0; i < 4; i++) step(1, 8'h1C + 8'(i), 0);
        step(1, 8'h2A, 1);
        tests++;
        if (overflow_out !== 1'b0) begin
            fails++; $display("FAIL full_pop_ovf got=%b exp=0", overflow_out);
        end
        foreach (exp[i]) begin
            tests++;
            if (head_now() !== {2'b00, exp[i]}) begin
                fails++;
                $display("FAIL full_pop_order%0d got=%h exp=%h", i, head_now(), {2'b00, exp[i]});
            end
            step(0, 8'h00, 1);
        end
    endtask

    task automatic test_timeout();
        step(1, 8'hE0, 0);
        repeat (TMO - 1) step(0, 8'h00, 0);
        tests++;
        if (timeout_out !== 1'b0) begin
            fails++; $display("FAIL timeout_early got=%b exp=0", timeout_out);
        end
        step(0, 8'h00, 0);
        tests++;
        if (timeout_out !== 1'b1) begin
            fails++; $display("FAIL timeout_pulse got=%b exp=1", timeout_out);
        end
        step(0, 8'h00, 0);
        tests++;
        if (timeout_out !== 1'b0) begin
            fails++; $display("FAIL timeout_width got=%b exp=0", timeout_out);
        end
        step(1, 8'h1C, 0);
        tests++;
        if (head_now() !== 10'h01C) begin
            fails++; $display("FAIL timeout_next got=%h exp=01c", head_now());
        end
        step(0, 8'h00, 1);
        // A byte arriving on the expiry cycle completes the sequence
        step(1, 8'hE0, 0);
        repeat (TMO - 1) step(0, 8'h00, 0);
        step(1, 8'h1C, 0);
        tests++;
        if (timeout_out !== 1'b0 || head_now() !== 10'h21C) begin
            fails++;
            $display("FAIL timeout_edge got=%b/%h exp=0/21c", timeout_out, head_now());
        end
        step(0, 8'h00, 1);
    endtask

    task automatic test_reset_mid();
        step(1, 8'h12, 0);
        step(1, 8'hF0, 0);
        rst_in = 1'b0;
        #1;
        tests++;
        if ({key_valid_out, shift_out} !== 2'b00) begin
            fails++;
            $display("FAIL async_reset got=%b exp=00", {key_valid_out, shift_out});
        end
        model_reset();
        #2;
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        step(1, 8'h1C, 0);
        tests++;
        if (key_valid_out !== 1'b1 || head_now() !== 10'h01C) begin
            fails++;
            $display("FAIL reset_brk_lost got=%b/%h exp=1/01c", key_valid_out, head_now());
        end
        step(0, 8'h00, 1);
    endtask

    task automatic test_random();
        logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'h14,
                                  8'h11, 8'h1C, 8'h75, 8'hAA, 8'hFA, 8'h00};
        int bad = 0;
        for (int n = 0; n < 400; n++) begin
            logic [7:0] b;
            int gap;
            if ($urandom_range(0, 3) == 0) b = 8'($urandom);
            else b = pool[$urandom_range(0, 11)];
            gap = ($urandom_range(0, 15) == 0) ? 18 : int'($urandom_range(0, 3));
            for (int g = 0; g <= gap; g++) begin
                step(g == 0, b, $urandom_range(0, 1) == 1);
                tests++;
                if (key_valid_out !== (m_q.size() != 0) ||
                    (m_q.size() != 0 && head_now() !== m_q[0]) ||
                    {shift_out, ctrl_out, alt_out} !== {m_ls | m_rs, m_ctrl, m_alt} ||
                    {overflow_out, timeout_out} !== {m_ovf, m_tmo}) begin
                    fails++;
                    bad++;
                    if (bad < 10)
                        $display("FAIL random n=%0d got v=%b h=%h m=%b p=%b exp v=%b h=%h m=%b p=%b",
                                 n, key_valid_out, head_now(), {shift_out, ctrl_out, alt_out},
                                 {overflow_out, timeout_out}, m_q.size() != 0,
                                 (m_q.size() != 0) ? m_q[0] : 10'h0,
                                 {m_ls | m_rs, m_ctrl, m_alt}, {m_ovf, m_tmo});
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_make_break();
        test_ext_break();
        test_modifiers();
        test_pause();
        test_overflow();
        test_push_pop_full();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
